// File: rtl/clock_switch_ctrl.sv
// Break-before-make sequencer for a glitch-free clock mux: verifies the target
// clock's heartbeat, then walks the one-hot select through an all-zero guard window.
module clock_switch_ctrl #(
    parameter int NUM_CLOCKS    = 3,
    parameter int DEFAULT_IDX   = 0,
    parameter int GUARD_CYCLES  = 64,
    parameter int SETTLE_CYCLES = 256,
    parameter int HB_TIMEOUT    = 1024,
    localparam int IDX_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [IDX_W-1:0]      req_idx,
    output logic                  req_ready,
    input  logic [NUM_CLOCKS-1:0] heartbeat,
    input  logic                  err_clear,
    output logic [NUM_CLOCKS-1:0] clk_select,
    output logic                  domain_reset,
    output logic [IDX_W-1:0]      cur_idx,
    output logic                  busy,
    output logic                  err_dead_clock,
    output logic                  err_bad_req,
    output logic [7:0]            switch_count
);

    localparam int CNT_MAX_GS = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_GS > HB_TIMEOUT) ? CNT_MAX_GS : HB_TIMEOUT;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HB_LAST     = CNT_W'(HB_TIMEOUT - 1);
    localparam logic [IDX_W:0]   NUM_CLK_EXT = (IDX_W + 1)'(NUM_CLOCKS);
    localparam logic [IDX_W-1:0] DEF_IDX     = IDX_W'(DEFAULT_IDX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ASSERT_RST,
        S_DESELECT,
        S_SELECT
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        target;
    logic [CNT_W-1:0]        cnt;
    logic                    edge_seen;
    logic [NUM_CLOCKS-1:0]   hb_sync1;
    logic [NUM_CLOCKS-1:0]   hb_sync2;
    logic [NUM_CLOCKS-1:0]   hb_hist;
    logic                    hb_hit;

    function automatic logic [NUM_CLOCKS-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NUM_CLOCKS'(1) << idx;
    endfunction

    // An edge is any change between the last synchronizer stage and its history flop.
    assign hb_hit    = |((hb_sync2 ^ hb_hist) & onehot(target));
    assign req_ready = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            // Reset lands in DESELECT so the startup sequence reuses the normal
            // guard/settle path toward DEFAULT_IDX.
            state          <= S_DESELECT;
            target         <= DEF_IDX;
            cur_idx        <= DEF_IDX;
            cnt            <= '0;
            edge_seen      <= 1'b0;
            clk_select     <= '0;
            domain_reset   <= 1'b1;
            busy           <= 1'b1;
            err_dead_clock <= 1'b0;
            err_bad_req    <= 1'b0;
            switch_count   <= '0;
            hb_sync1       <= '0;
            hb_sync2       <= '0;
            hb_hist        <= '0;
        end else begin
            hb_sync1 <= heartbeat;
            hb_sync2 <= hb_sync1;
            hb_hist  <= hb_sync2;

            // NOTE: non-blocking assignments let a later set in the FSM below
            // override this clear within the same edge, so a new error wins.
            if (err_clear) begin
                err_dead_clock <= 1'b0;
                err_bad_req    <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if ({1'b0, req_idx} >= NUM_CLK_EXT) begin
                            err_bad_req <= 1'b1;
                        end else if (req_idx != cur_idx) begin
                            target    <= req_idx;
                            state     <= S_CHECK;
                            busy      <= 1'b1;
                            cnt       <= '0;
                            edge_seen <= 1'b0;
                        end
                    end
                end

                S_CHECK: begin
                    if (hb_hit && edge_seen) begin
                        state        <= S_ASSERT_RST;
                        domain_reset <= 1'b1;
                    end else begin
                        if (hb_hit) begin
                            edge_seen <= 1'b1;
                        end
                        if (cnt == HB_LAST) begin
                            err_dead_clock <= 1'b1;
                            state          <= S_IDLE;
                            busy           <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                S_ASSERT_RST: begin
                    state      <= S_DESELECT;
                    clk_select <= '0;
                    cnt        <= '0;
                end

                S_DESELECT: begin
                    if (cnt == GUARD_LAST) begin
                        state      <= S_SELECT;
                        clk_select <= onehot(target);
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_SELECT: begin
                    if (cnt == SETTLE_LAST) begin
                        state        <= S_IDLE;
                        busy         <= 1'b0;
                        domain_reset <= 1'b0;
                        cur_idx      <= target;
                        // Startup selects the already-committed source and is not counted.
                        if (target != cur_idx) begin
                            switch_count <= switch_count + 8'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state        <= S_DESELECT;
                    clk_select   <= '0;
                    domain_reset <= 1'b1;
                    busy         <= 1'b1;
                    cnt          <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Directed bench for clock_switch_ctrl: startup, good/dead switches, request table,
// mid-switch reset and switch_count wrap with a held request.
module tb_clock_switch_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_idx;
    logic       req_ready;
    logic [2:0] heartbeat;
    logic       err_clear;
    logic [2:0] clk_select;
    logic       domain_reset;
    logic [1:0] cur_idx;
    logic       busy;
    logic       err_dead_clock;
    logic       err_bad_req;
    logic [7:0] switch_count;

    int n_checks = 0;
    int n_errors = 0;

    // Sources 0 and 2 are alive, source 1 is dead.
    logic [2:0] hb_mask = 3'b101;

    clock_switch_ctrl #(
        .NUM_CLOCKS(3), .DEFAULT_IDX(0), .GUARD_CYCLES(4), .SETTLE_CYCLES(8), .HB_TIMEOUT(32)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_idx(req_idx),
        .req_ready(req_ready), .heartbeat(heartbeat), .err_clear(err_clear),
        .clk_select(clk_select), .domain_reset(domain_reset), .cur_idx(cur_idx),
        .busy(busy), .err_dead_clock(err_dead_clock), .err_bad_req(err_bad_req),
        .switch_count(switch_count)
    );

    always #5 clk = ~clk;

    initial begin
        heartbeat = '0;
        forever begin
            repeat (3) @(posedge clk);
            #3 heartbeat = heartbeat ^ hb_mask;
        end
    end

    typedef struct {
        logic       valid;
        logic [1:0] idx;
        logic       clr;
        logic [2:0] exp_sel;
        logic [1:0] exp_cur;
        logic       exp_bad;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample just after the edge; the select must never be multi-hot.
    task automatic tick();
        @(posedge clk);
        #1;
        check("sel_onehot0", 32'($onehot0(clk_select)), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic check_startup();
        for (int i = 0; i < 4; i++) begin
            check("startup_guard_sel", 32'(clk_select), 32'b000);
            check("startup_guard_rst", 32'(domain_reset), 32'd1);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            check("startup_settle_sel", 32'(clk_select), 32'b001);
            check("startup_settle_rst", 32'(domain_reset), 32'd1);
            tick();
        end
        check("startup_idle_rst", 32'(domain_reset), 32'd0);
        check("startup_idle_ready", 32'(req_ready), 32'd1);
        check("startup_idle_busy", 32'(busy), 32'd0);
        check("startup_idle_cur", 32'(cur_idx), 32'd0);
        check("startup_idle_count", 32'(switch_count), 32'd0);
    endtask

    task automatic check_reset_values();
        check("rst_sel", 32'(clk_select), 32'b000);
        check("rst_domain", 32'(domain_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_cur", 32'(cur_idx), 32'd0);
        check("rst_count", 32'(switch_count), 32'd0);
        check("rst_err_dead", 32'(err_dead_clock), 32'd0);
        check("rst_err_bad", 32'(err_bad_req), 32'd0);
    endtask

    initial begin
        int   n;
        logic [1:0] exp_cur;
        logic [7:0] exp_count;

        reset = 1'b1; req_valid = 1'b0; req_idx = '0; err_clear = 1'b0;

        // Reset and startup sequence.
        tick(); tick();
        check_reset_values();
        reset = 1'b0;
        check_startup();

        // Good switch 0 -> 2.
        req_valid = 1'b1; req_idx = 2'd2;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!domain_reset && n < 60) begin
            check("check_old_sel", 32'(clk_select), 32'b001);
            check("check_busy", 32'(busy), 32'd1);
            tick();
            n++;
        end
        check("assert_rst_seen", 32'(domain_reset), 32'd1);
        check("assert_rst_old_sel", 32'(clk_select), 32'b001);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("guard_sel", 32'(clk_select), 32'b000);
            check("guard_rst", 32'(domain_reset), 32'd1);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            check("settle_sel", 32'(clk_select), 32'b100);
            check("settle_rst", 32'(domain_reset), 32'd1);
            tick();
        end
        check("switch_idle_busy", 32'(busy), 32'd0);
        check("switch_idle_rst", 32'(domain_reset), 32'd0);
        check("switch_cur", 32'(cur_idx), 32'd2);
        check("switch_count_1", 32'(switch_count), 32'd1);

        // Dead clock: source 1 never toggles.
        req_valid = 1'b1; req_idx = 2'd1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("dead_busy", 32'(busy), 32'd1);
            check("dead_no_rst", 32'(domain_reset), 32'd0);
            check("dead_sel", 32'(clk_select), 32'b100);
            tick();
        end
        check("dead_idle", 32'(busy), 32'd0);
        check("dead_flag", 32'(err_dead_clock), 32'd1);
        check("dead_sel_kept", 32'(clk_select), 32'b100);
        check("dead_cur_kept", 32'(cur_idx), 32'd2);
        check("dead_count_kept", 32'(switch_count), 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("dead_cleared", 32'(err_dead_clock), 32'd0);

        // Request table while idle on source 2.
        vecs[0] = '{1'b1, 2'd2, 1'b0, 3'b100, 2'd2, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 2'd3, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 2'd0, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 2'd0, 1'b1, 3'b100, 2'd2, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 2'd3, 1'b1, 3'b100, 2'd2, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 2'd3, 1'b1, 3'b100, 2'd2, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 2'd1, 1'b0, 3'b100, 2'd2, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            req_valid = vecs[i].valid; req_idx = vecs[i].idx; err_clear = vecs[i].clr;
            tick();
            req_valid = 1'b0; err_clear = 1'b0;
            check("vec_sel", 32'(clk_select), 32'(vecs[i].exp_sel));
            check("vec_cur", 32'(cur_idx), 32'(vecs[i].exp_cur));
            check("vec_bad", 32'(err_bad_req), 32'(vecs[i].exp_bad));
            check("vec_busy", 32'(busy), 32'(vecs[i].exp_busy));
            check("vec_count", 32'(switch_count), 32'd1);
        end

        // Mid-switch reset: switching 2 -> 0, reset while settling.
        req_valid = 1'b1; req_idx = 2'd0;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!(clk_select == 3'b001 && busy) && n < 100) begin
            tick();
            n++;
        end
        check("midsw_in_select", 32'(clk_select), 32'b001);
        tick(); tick();
        reset = 1'b1;
        tick();
        check_reset_values();
        reset = 1'b0;
        check_startup();

        // Counter wrap with req_valid held high through every switch.
        exp_cur = 2'd0;
        exp_count = 8'd0;
        req_valid = 1'b1;
        for (int k = 0; k < 256; k++) begin
            wait_idle();
            check("wrap_count", 32'(switch_count), 32'(exp_count));
            check("wrap_cur", 32'(cur_idx), 32'(exp_cur));
            req_idx = (exp_cur == 2'd0) ? 2'd2 : 2'd0;
            tick();
            check("held_accept_first_idle", 32'(busy), 32'd1);
            exp_cur = req_idx;
            exp_count = exp_count + 8'd1;
        end
        wait_idle();
        check("wrap_to_zero", 32'(switch_count), 32'd0);
        check("wrap_final_cur", 32'(cur_idx), 32'd0);
        req_valid = 1'b0;
        tick();
        check("final_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
